mips_rtype_sequencer: RTL

MIPS_RTYPE_SEQUENCER -- requirements
Module: mips_rtype_sequencer

---
 rtl/mips_seq_pkg.sv | 55 +++++
 rtl/mips_instr_buf.sv | 28 ++
 rtl/mips_rtype_sequencer.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/mips_seq_pkg.sv
// Shared definitions for the R-type sequencer: FSM states, MIPS field
// constants, the default program buffer depth and small decode helpers.
package mips_seq_pkg;

  // Default number of program buffer entries (must be a power of two)
  localparam int DEPTH_DEFAULT = 16;

  // Opcode field value shared by every R-type instruction
  localparam logic [5:0] R_TYPE = 6'h00;

  // Function codes the external core knows how to execute
  localparam logic [5:0] FUNCT_ADD  = 6'h20;
  localparam logic [5:0] FUNCT_ADDU = 6'h21;
  localparam logic [5:0] FUNCT_SUB  = 6'h22;
  localparam logic [5:0] FUNCT_AND  = 6'h24;
  localparam logic [5:0] FUNCT_OR   = 6'h25;
  localparam logic [5:0] FUNCT_SLL  = 6'h00;
  localparam logic [5:0] FUNCT_SRL  = 6'h02;
  localparam logic [5:0] FUNCT_SRA  = 6'h03;
  localparam logic [5:0] FUNCT_SLTU = 6'h2B;

  // All-zero word is sll $0,$0,0, i.e. a harmless NOP for the core
  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

  // Sequencer states; one instruction walks ISSUE -> CAPTURE -> WRITE
  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    CAPTURE,
    WRITE,
    DONE
  } seq_state_t;

  // Destination register field of an R-type word
  function automatic logic [4:0] rd_field(input logic [31:0] instr);
    return instr[15:11];
  endfunction

  // True when the word is an R-type the core supports
  function automatic logic is_legal(input logic [31:0] instr);
    logic ok;
    ok = 1'b0;
    if (instr[31:26] == R_TYPE) begin
      case (instr[5:0])
        FUNCT_ADD, FUNCT_ADDU, FUNCT_SUB,
        FUNCT_AND, FUNCT_OR,
        FUNCT_SLL, FUNCT_SRL, FUNCT_SRA,
        FUNCT_SLTU: ok = 1'b1;
        default:    ok = 1'b0;
      endcase
    end
    return ok;
  endfunction

endpackage

// File: rtl/mips_instr_buf.sv
// Program storage for the sequencer: synchronous write port used while
// loading, asynchronous read port feeding the issue logic. Contents are
// deliberately not reset so a program survives a reset and can be rerun.
module mips_instr_buf
  import mips_seq_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEFAULT
) (
  input  logic                       clock,
  input  logic                       wr_en,
  input  logic [$clog2(DEPTH)-1:0]   wr_addr,
  input  logic [31:0]                wr_data,
  input  logic [$clog2(DEPTH)-1:0]   rd_addr,
  output logic [31:0]                rd_data
);

  logic [31:0] mem [DEPTH];

  // Store one instruction word per enabled cycle
  always_ff @(posedge clock) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/mips_rtype_sequencer.sv
// Steps through a small buffered program of R-type instructions, presenting
// each one to an external combinational core for two cycles, capturing the
// core result and issuing a register write-back strobe. Illegal words are
// flagged and skipped without stalling the program.
module mips_rtype_sequencer
  import mips_seq_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEFAULT
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      load_valid,
  input  logic [$clog2(DEPTH)-1:0]  load_addr,
  input  logic [31:0]               load_data,
  input  logic                      start,
  input  logic [4:0]                prog_len,
  output logic [31:0]               core_instr,
  input  logic [31:0]               core_result,
  output logic                      wb_valid,
  output logic [4:0]                wb_rd,
  output logic [31:0]               wb_data,
  output logic                      busy,
  output logic                      done,
  output logic                      error
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;

  seq_state_t     state;
  logic [PW-1:0]  pc;
  logic [LW-1:0]  len;
  logic [LW-1:0]  start_len;
  logic [PW-1:0]  rd_addr;
  logic [31:0]    rd_data;
  logic           buf_wr_en;
  logic           last;

  // Loads are only accepted while idle and never in a reset cycle
  assign buf_wr_en = load_valid && (state == IDLE) && !reset;

  // Current entry is the final one of the program
  assign last = ({1'b0, pc} == (len - 1'b1));

  mips_instr_buf #(
    .DEPTH (DEPTH)
  ) u_instr_buf (
    .clock   (clock),
    .wr_en   (buf_wr_en),
    .wr_addr (load_addr),
    .wr_data (load_data),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

  // Clamp the requested length so pc can never run past the buffer
  always_comb begin
    start_len = '0;
    if (32'(prog_len) > DEPTH) begin
      start_len = LW'(DEPTH);
    end else begin
      start_len = LW'(prog_len);
    end
  end

  // Look ahead to the entry that will be issued next so core_instr can be registered
  always_comb begin
    rd_addr = pc;
    if (state == IDLE) begin
      rd_addr = '0;
    end else if ((state == WRITE) && !last) begin
      rd_addr = pc + 1'b1;
    end
  end

  // Sequencer FSM with all outputs registered
  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      pc         <= '0;
      len        <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      wb_valid   <= 1'b0;
      wb_rd      <= '0;
      wb_data    <= '0;
      error      <= 1'b0;
      core_instr <= NOP_INSTR;
    end else begin
      done     <= 1'b0;
      wb_valid <= 1'b0;
      case (state)
        IDLE: begin
          core_instr <= NOP_INSTR;
          if (start) begin
            pc    <= '0;
            len   <= start_len;
            error <= 1'b0;
            busy  <= 1'b1;
            if (start_len != '0) begin
              state      <= ISSUE;
              core_instr <= rd_data;
            end else begin
              state <= DONE;
              done  <= 1'b1;
            end
          end
        end
        ISSUE: begin
          state <= CAPTURE;
        end
        CAPTURE: begin
          wb_data    <= core_result;
          wb_rd      <= rd_field(core_instr);
          core_instr <= NOP_INSTR;
          state      <= WRITE;
          if (is_legal(core_instr)) begin
            wb_valid <= (rd_field(core_instr) != 5'd0);
          end else begin
            error <= 1'b1;
          end
        end
        WRITE: begin
          if (last) begin
            state <= DONE;
            done  <= 1'b1;
          end else begin
            pc         <= pc + 1'b1;
            core_instr <= rd_data;
            state      <= ISSUE;
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state      <= IDLE;
          busy       <= 1'b0;
          core_instr <= NOP_INSTR;
        end
      endcase
    end
  end

endmodule
